// File: rtl/sreg_xfer_pkg.sv
// Shared definitions for the sreg_xfer shift engine: FSM encodings, default sizes, length clamp.
package sreg_xfer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LANES = 1;
  localparam int DEF_CNT_W = 5;
  localparam int DEF_DIV_W = 8;

  // A length of 0, or anything longer than the register, means a full-width transfer.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/sreg_xfer_if.sv
// Control/data bundle between a host FSM (master) and the sreg_xfer bit engine (slave).
interface sreg_xfer_if
  import sreg_xfer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
);

  logic [LANES*WIDTH-1:0] pin;
  logic                   start;
  logic                   abort;
  logic [CNT_W-1:0]       len;
  logic                   msb_first;
  logic [DIV_W-1:0]       div;
  logic [LANES-1:0]       sin;
  logic [LANES-1:0]       sout;
  logic                   shift_stb;
  logic                   busy;
  logic                   done;
  logic [LANES*WIDTH-1:0] pout;

  modport master (
    output pin, start, abort, len, msb_first, div, sin,
    input  sout, shift_stb, busy, done, pout
  );

  modport slave (
    input  pin, start, abort, len, msb_first, div, sin,
    output sout, shift_stb, busy, done, pout
  );

endinterface

// File: rtl/sreg_xfer_tick.sv
// Reloadable down-counter producing a shift tick every div+1 enabled cycles.
// Latency: first tick div+1 cycles after load; no backpressure, runs whenever en is high.
module sreg_xfer_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  assign tick = en && (cnt == '0);

  // The divider is captured at load so later changes on div cannot disturb the rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= div;
      reload <= div;
    end else if (en) begin
      cnt <= tick ? reload : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/sreg_xfer.sv
// Multi-lane full-duplex shift engine: parallel load, LEN shifts at div+1 rate, one-cycle done.
// Latency: done L*(div+1)+1 cycles after accept; start is ignored (not queued) while busy.
module sreg_xfer
  import sreg_xfer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic        clk,
  input  logic        reset,
  sreg_xfer_if.slave  bus
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] last_idx;
  logic             msb_q;
  logic             tick;
  logic             accept;
  logic             shift_en;
  logic             last_shift;

  // DONE counts as idle so a held start chains transfers without a dead cycle.
  assign accept     = (state == ST_IDLE || state == ST_DONE) && bus.start && !bus.abort;
  assign shift_en   = (state == ST_SHIFT) && tick;
  assign last_shift = shift_en && (bit_cnt == last_idx);

  sreg_xfer_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (state == ST_SHIFT),
    .div   (bus.div),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        // Abort outranks completion: a final shift landing with abort still ends without done.
        if (bus.abort)       state_nxt = ST_IDLE;
        else if (last_shift) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      last_idx <= '0;
      msb_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bit_cnt  <= '0;
        last_idx <= CNT_W'(clamp_len(32'(bus.len), WIDTH) - 1);
        msb_q    <= bus.msb_first;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sr <= '0;
      end else if (accept) begin
        sr <= bus.pin[k*WIDTH +: WIDTH];
      end else if (shift_en) begin
        sr <= msb_q ? {sr[WIDTH-2:0], bus.sin[k]} : {bus.sin[k], sr[WIDTH-1:1]};
      end
    end

    assign bus.pout[k*WIDTH +: WIDTH] = sr;
    assign bus.sout[k]                = msb_q ? sr[WIDTH-1] : sr[0];
  end

  assign bus.shift_stb = shift_en;
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_sreg_xfer.sv
// Directed bench for sreg_xfer with two 16-bit lanes: vector table plus abort/chain/reset sequences.
module tb_sreg_xfer;

  localparam int WIDTH = 16;
  localparam int LANES = 2;
  localparam int CNT_W = 5;
  localparam int DIV_W = 8;

  typedef struct {
    logic [31:0] pin;
    logic [4:0]  len;
    logic        msb;
    logic [7:0]  div;
    logic [1:0]  sin;
    bit          loopback;
    logic [31:0] exp_pout;
    logic [15:0] exp_seq;
    int          exp_stb;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic loopback;
  logic [1:0] sin_drv;

  int checks = 0;
  int errors = 0;
  int stb_total = 0;
  int done_total = 0;

  vec_t vecs[6];

  sreg_xfer_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  sreg_xfer #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.sin = loopback ? bus.sout : sin_drv;

  always @(posedge clk) begin
    if (bus.shift_stb) stb_total++;
    if (bus.done)      done_total++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one transfer and follow it to done, collecting lane-0 sout on every shift.
  task automatic run_xfer(input vec_t v, input int idx, output int lat, output logic [15:0] seq,
                          output int nstb);
    bit got;
    @(negedge clk);
    bus.pin = v.pin; bus.len = v.len; bus.msb_first = v.msb; bus.div = v.div;
    sin_drv = v.sin; loopback = v.loopback; bus.start = 1'b1;
    lat = 0; seq = '0; nstb = 0; got = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.pin = 32'hDEAD_BEEF; bus.len = 5'd3; bus.msb_first = ~v.msb; bus.div = 8'd7;
        chk($sformatf("v%0d_busy_c1", idx), 32'(bus.busy), 32'd1);
      end
      if (bus.shift_stb) begin
        seq = {seq[14:0], bus.sout[0]};
        nstb++;
      end
      if (bus.done) begin
        got = 1;
        lat = c;
        chk($sformatf("v%0d_busy_at_done", idx), 32'(bus.busy), 32'd0);
      end
    end
    if (!got) chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
  endtask

  initial begin
    int lat, nstb, base_s, base_d;
    logic [15:0] seq;
    bit hit;

    reset = 1'b1; loopback = 1'b0; sin_drv = 2'b00;
    bus.pin = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0;
    bus.msb_first = 1'b0; bus.div = '0;

    //                pin           len    msb   div   sin    loop  exp_pout      seq       stb lat
    vecs[0] = '{32'h0F0F_A5C3, 5'd0,  1'b1, 8'd0, 2'b00, 1'b1, 32'h0F0F_A5C3, 16'hA5C3, 16, 17};
    vecs[1] = '{32'h1234_00F1, 5'd8,  1'b0, 8'd3, 2'b11, 1'b0, 32'hFF12_FF00, 16'h008F, 8,  33};
    vecs[2] = '{32'h1234_FFFF, 5'd16, 1'b1, 8'd0, 2'b10, 1'b0, 32'hFFFF_0000, 16'hFFFF, 16, 17};
    vecs[3] = '{32'h0000_8001, 5'd20, 1'b1, 8'd0, 2'b01, 1'b0, 32'h0000_FFFF, 16'h8001, 16, 17};
    vecs[4] = '{32'h1234_ABCD, 5'd4,  1'b1, 8'd1, 2'b10, 1'b0, 32'h234F_BCD0, 16'h000A, 4,  9};
    vecs[5] = '{32'h8000_0001, 5'd1,  1'b0, 8'd0, 2'b01, 1'b0, 32'h4000_8000, 16'h0001, 1,  2};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_stb",  32'(bus.shift_stb), 32'd0);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_pout", bus.pout, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i], i, lat, seq, nstb);
      chk($sformatf("v%0d_pout", i), bus.pout, vecs[i].exp_pout);
      chk($sformatf("v%0d_sout_seq", i), 32'(seq), 32'(vecs[i].exp_seq));
      chk($sformatf("v%0d_nshift", i), 32'(nstb), 32'(vecs[i].exp_stb));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_pout_hold", i), bus.pout, vecs[i].exp_pout);
    end
    loopback = 1'b0;

    // Abort after the 5th shift; start held while busy must not restart anything.
    bus.pin = 32'h0000_FFFF; bus.len = 5'd0; bus.msb_first = 1'b1; bus.div = 8'd2; sin_drv = 2'b00;
    @(negedge clk);
    base_s = stb_total; base_d = done_total;
    bus.start = 1'b1;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (stb_total - base_s == 5) hit = 1;
    end
    chk("abort_reach5", 32'(hit), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_nshift", 32'(stb_total - base_s), 32'd5);
    chk("abort_ndone",  32'(done_total - base_d), 32'd0);
    chk("abort_pout",   bus.pout, 32'h0000_FFE0);

    // Start and abort together in idle: abort wins.
    bus.pin = 32'h1234_5678; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 32'd0);
    chk("sa_pout", bus.pout, 32'h0000_FFE0);

    // Start held through DONE chains a second transfer with no idle cycle.
    bus.pin = 32'h5555_00F0; bus.len = 5'd2; bus.msb_first = 1'b1; bus.div = 8'd0; sin_drv = 2'b00;
    base_d = done_total;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("chain_done1", 32'(bus.done), 32'd1);
    chk("chain_busy_at_done", 32'(bus.busy), 32'd0);
    chk("chain_pout1", bus.pout, 32'h5554_03C0);
    bus.pin = 32'hAAAA_0F00;
    @(negedge clk);
    bus.start = 1'b0;
    chk("chain_busy2", 32'(bus.busy), 32'd1);
    chk("chain_load2", bus.pout, 32'hAAAA_0F00);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (bus.done) hit = 1;
    end
    chk("chain_done2", 32'(hit), 32'd1);
    chk("chain_pout2", bus.pout, 32'hAAA8_3C00);
    @(negedge clk);
    chk("chain_ndone", 32'(done_total - base_d), 32'd2);

    // Asynchronous reset in the middle of a transfer.
    bus.pin = 32'hFFFF_FFFF; bus.len = 5'd0; bus.msb_first = 1'b1; bus.div = 8'd0; sin_drv = 2'b11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    base_d = done_total;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_stb",  32'(bus.shift_stb), 32'd0);
    chk("arst_sout", 32'(bus.sout), 32'd0);
    chk("arst_pout", bus.pout, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_ndone", 32'(done_total - base_d), 32'd0);
    chk("arst_idle",  32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
